// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine with HI/LO registers; WIDTH+1 cycle latency, Busy stalls issue, Start ignored while Busy.
// Define MULDIV_EARLY_TERM_EN to end multiplies once the remaining multiplier bits are zero.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Flush,
   input  logic             MtHi,
   input  logic             MtLo,
   input  logic [WIDTH-1:0] MtData,
   output logic             Busy,
   output logic             Done,
   output logic             DivByZero,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ITER = 2'd1, S_FIX = 2'd2} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [1:0]         op_q, op_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
   logic               done_q, done_d, dbz_q, dbz_d;

   logic               in_signed, is_div, sign_a, sign_b, neg_res, last_iter;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     rem_sh, rem_diff;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix;

   assign in_signed = ~Op[0];
   assign mag_a     = (in_signed && A[WIDTH-1]) ? -A : A;
   assign mag_b     = (in_signed && B[WIDTH-1]) ? -B : B;

   assign is_div  = op_q[1];
   assign sign_a  = ~op_q[0] & a_q[WIDTH-1];
   assign sign_b  = ~op_q[0] & b_q[WIDTH-1];
   assign neg_res = sign_a ^ sign_b;

   // Divide keeps {remainder, dividend/quotient} in acc_q; a borrow out of bit WIDTH means restore.
   assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign rem_diff = rem_sh - {1'b0, mcand_q[WIDTH-1:0]};

   assign prod_fix = neg_res ? -acc_q : acc_q;
   assign quot_fix = neg_res ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign rem_fix  = sign_a ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

`ifdef MULDIV_EARLY_TERM_EN
   assign last_iter = is_div ? (cnt_q == CW'(WIDTH-1)) : (mplier_q[WIDTH-1:1] == '0);
`else
   assign last_iter = (cnt_q == CW'(WIDTH-1));
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      dbz_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (MtHi) hi_d = MtData;
            if (MtLo) lo_d = MtData;
            if (Start && !Flush) begin
               state_d  = S_ITER;
               cnt_d    = '0;
               op_d     = Op;
               a_d      = A;
               b_d      = B;
               acc_d    = Op[1] ? {{WIDTH{1'b0}}, mag_a} : '0;
               mcand_d  = Op[1] ? {{WIDTH{1'b0}}, mag_b} : {{WIDTH{1'b0}}, mag_a};
               mplier_d = mag_b;
            end
         end
         S_ITER: begin
            if (Flush) begin
               state_d = S_IDLE;
            end else begin
               if (is_div) begin
                  acc_d = rem_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                          : {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
               end else begin
                  if (mplier_q[0]) acc_d = acc_q + mcand_q;
                  mcand_d  = mcand_q << 1;
                  mplier_d = mplier_q >> 1;
               end
               cnt_d = cnt_q + CW'(1);
               if (last_iter) state_d = S_FIX;
            end
         end
         S_FIX: begin
            state_d = S_IDLE;
            if (!Flush) begin
               done_d = 1'b1;
               if (!is_div) begin
                  hi_d = prod_fix[2*WIDTH-1:WIDTH];
                  lo_d = prod_fix[WIDTH-1:0];
               end else if (b_q == '0) begin
                  hi_d  = a_q;
                  lo_d  = '1;
                  dbz_d = 1'b1;
               end else begin
                  hi_d = rem_fix;
                  lo_d = quot_fix;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
         dbz_q    <= dbz_d;
      end
   end

   assign Busy      = (state_q != S_IDLE);
   assign Done      = done_q;
   assign DivByZero = dbz_q;
   assign Hi        = hi_q;
   assign Lo        = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors queue expected HI/LO/DivByZero and Done cycle; a monitor checks each Done.
module tb_muldiv_unit;
   localparam int W = 32;

   logic         Clk = 1'b0, Reset = 1'b1, Start = 1'b0, Flush = 1'b0, MtHi = 1'b0, MtLo = 1'b0;
   logic [1:0]   Op = 2'b00;
   logic [W-1:0] A = '0, B = '0, MtData = '0;
   logic         Busy, Done, DivByZero;
   logic [W-1:0] Hi, Lo;

   typedef struct {
      int           id;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
      int           cyc;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   cyc = 0;
   int   checks = 0;
   int   fails = 0;

   muldiv_unit #(.WIDTH(W)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B), .Flush(Flush),
      .MtHi(MtHi), .MtLo(MtLo), .MtData(MtData), .Busy(Busy), .Done(Done),
      .DivByZero(DivByZero), .Hi(Hi), .Lo(Lo)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Expected iteration count: full WIDTH, or bit-length of |B| for early-terminated multiplies.
   function automatic int iters(input logic [1:0] op, input logic [W-1:0] b);
      int n;
      n = W;
`ifdef MULDIV_EARLY_TERM_EN
      if (!op[1]) begin
         logic [W-1:0] m;
         m = (!op[0] && b[W-1]) ? -b : b;
         n = 1;
         for (int i = 0; i < W; i++) if (m[i]) n = i + 1;
      end
`endif
      return n;
   endfunction

   always @(negedge Clk) begin
      if (Reset === 1'b1 && Done === 1'b1) begin
         if (q.size() == 0) begin
            chk("unexpected_done", {63'd0, Done}, 64'd0);
         end else begin
            mon_e = q.pop_front();
            chk($sformatf("op%0d_hi", mon_e.id), Hi, mon_e.hi);
            chk($sformatf("op%0d_lo", mon_e.id), Lo, mon_e.lo);
            chk($sformatf("op%0d_dbz", mon_e.id), DivByZero, mon_e.dbz);
            chk($sformatf("op%0d_done_cycle", mon_e.id), cyc, mon_e.cyc);
         end
      end else if (Reset === 1'b1 && DivByZero === 1'b1) begin
         chk("dbz_without_done", DivByZero, 64'd0);
      end
   end

   task automatic run_op(input int id, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edbz,
                         input bit restart, input bit mt);
      exp_t e;
      int   n;
      int   it;
      it = iters(op, b);
      @(negedge Clk);
      Op = op; A = a; B = b; Start = 1'b1;
      if (mt) begin
         MtHi = 1'b1;
         MtData = 32'h0000AAAA;
      end
      e.id = id; e.hi = ehi; e.lo = elo; e.dbz = edbz; e.cyc = cyc + it + 2;
      q.push_back(e);
      @(negedge Clk);
      Start = 1'b0; MtHi = 1'b0;
      Op = ~op; A = $urandom; B = $urandom;
      if (mt) chk($sformatf("op%0d_mthi_first", id), Hi, 32'h0000AAAA);
      n = 0;
      while (Busy === 1'b1 && n < 200) begin
         n++;
         if (restart && n == 3) begin
            Start = 1'b1; Op = 2'b01; A = 32'd1; B = 32'd1;
         end else begin
            Start = 1'b0;
         end
         @(negedge Clk);
      end
      Start = 1'b0;
      chk($sformatf("op%0d_busy_cycles", id), n, it + 1);
      @(negedge Clk);
   endtask

   initial begin
      #3 Reset = 1'b0;
      #1;
      chk("reset_hi", Hi, 0);
      chk("reset_lo", Lo, 0);
      chk("reset_busy", Busy, 0);
      chk("reset_done", Done, 0);
      chk("reset_dbz", DivByZero, 0);
      @(negedge Clk);
      Reset = 1'b1;

      run_op(1, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 0, 0);
      run_op(2, 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1, 0);
      run_op(3, 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0, 0);
      run_op(4, 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 0, 0);
      run_op(5, 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1, 0, 0);
      run_op(6, 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 0, 0);
      run_op(7, 2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, 0, 0);
      run_op(8, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1, 1'b0, 0, 0);
      run_op(9, 2'b01, 32'd9, 32'd1, 32'd0, 32'd9, 1'b0, 0, 0);
      run_op(10, 2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 0, 1);

      // MTHI/MTLO then a flushed multiply must leave the moved values intact.
      @(negedge Clk);
      MtHi = 1'b1; MtData = 32'h00001234;
      @(negedge Clk);
      MtHi = 1'b0; MtLo = 1'b1; MtData = 32'h00005678;
      @(negedge Clk);
      MtLo = 1'b0;
      chk("mthi", Hi, 32'h00001234);
      chk("mtlo", Lo, 32'h00005678);
      Op = 2'b01; A = 32'd3; B = 32'hFFFF0000; Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      chk("flush_busy_before", Busy, 1);
      repeat (8) @(negedge Clk);
      Flush = 1'b1;
      @(negedge Clk);
      Flush = 1'b0;
      chk("flush_busy_after", Busy, 0);
      chk("flush_hi", Hi, 32'h00001234);
      chk("flush_lo", Lo, 32'h00005678);
      repeat (40) @(negedge Clk);
      chk("flush_hi_later", Hi, 32'h00001234);
      chk("flush_busy_later", Busy, 0);

      run_op(11, 2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 0, 0);

      // Asynchronous reset in the middle of an operation.
      @(negedge Clk);
      Op = 2'b01; A = 32'd5; B = 32'hFFFF0000; Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      repeat (4) @(negedge Clk);
      #2 Reset = 1'b0;
      #1;
      chk("midreset_busy", Busy, 0);
      chk("midreset_hi", Hi, 0);
      chk("midreset_lo", Lo, 0);
      @(negedge Clk);
      Reset = 1'b1;
      repeat (5) @(negedge Clk);
      chk("postreset_busy", Busy, 0);
      chk("scoreboard_empty", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
